// File: rtl/stack_alu.sv
// stack_alu: parametrised push/operate stack core with status flags.
// Optional saturating ADD/SUB/INC/DEC when STACK_ALU_SAT_EN is defined.
module stack_alu #(
  parameter int W = 16,
  parameter int DEPTH = 8,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  in,
  input  logic [3:0]    op,
  input  logic          apply,
  output logic [W-1:0]  head,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count,
  output logic          valid,
  output logic          err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef STACK_ALU_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_NOT  = 4'd6;
  localparam logic [3:0] OP_PUSH = 4'd7;
  localparam logic [3:0] OP_POP  = 4'd8;
  localparam logic [3:0] OP_DUP  = 4'd9;
  localparam logic [3:0] OP_SWAP = 4'd10;
  localparam logic [3:0] OP_CLR  = 4'd11;
  localparam logic [3:0] OP_INC  = 4'd12;
  localparam logic [3:0] OP_DEC  = 4'd13;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          valid_q, valid_d;

  logic [AW-1:0] ia, ib, ip;
  logic [W-1:0]  a, b;
  logic [W:0]    sum, inc;
  logic          ge1, ge2, room, ok;

  assign ib   = AW'(cnt_q - CW'(1));
  assign ia   = AW'(cnt_q - CW'(2));
  assign ip   = AW'(cnt_q);
  assign a    = mem_q[ia];
  assign b    = mem_q[ib];
  assign sum  = {1'b0, a} + {1'b0, b};
  assign inc  = {1'b0, b} + (W+1)'(1);
  assign ge1  = cnt_q >= CW'(1);
  assign ge2  = cnt_q >= CW'(2);
  assign room = cnt_q < CW'(DEPTH);

  always_comb begin
    mem_d = mem_q;
    cnt_d = cnt_q;
    err_d = err_q;
    ok    = 1'b0;
    if (apply) begin
      unique case (op)
        OP_NOP: ok = 1'b1;
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: if (ge2) begin
          ok    = 1'b1;
          cnt_d = cnt_q - CW'(1);
          unique case (op)
            OP_ADD:  mem_d[ia] = (SAT && sum[W]) ? '1 : sum[W-1:0];
            OP_SUB:  mem_d[ia] = (SAT && a < b) ? '0 : a - b;
            OP_AND:  mem_d[ia] = a & b;
            OP_OR:   mem_d[ia] = a | b;
            default: mem_d[ia] = a ^ b;
          endcase
        end
        OP_NOT: if (ge1) begin
          ok        = 1'b1;
          mem_d[ib] = ~b;
        end
        OP_INC: if (ge1) begin
          ok        = 1'b1;
          mem_d[ib] = (SAT && inc[W]) ? '1 : inc[W-1:0];
        end
        OP_DEC: if (ge1) begin
          ok        = 1'b1;
          mem_d[ib] = (SAT && b == '0) ? '0 : b - W'(1);
        end
        OP_PUSH: if (room) begin
          ok        = 1'b1;
          mem_d[ip] = in;
          cnt_d     = cnt_q + CW'(1);
        end
        OP_POP: if (ge1) begin
          ok    = 1'b1;
          cnt_d = cnt_q - CW'(1);
        end
        OP_DUP: if (ge1 && room) begin
          ok        = 1'b1;
          mem_d[ip] = b;
          cnt_d     = cnt_q + CW'(1);
        end
        OP_SWAP: if (ge2) begin
          ok        = 1'b1;
          mem_d[ia] = b;
          mem_d[ib] = a;
        end
        OP_CLR: begin
          ok    = 1'b1;
          cnt_d = '0;
          err_d = 1'b0;
        end
        default: ok = 1'b0;
      endcase
      if (!ok) err_d = 1'b1;
    end
    valid_d = apply & ok;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q   <= '{default: '0};
      cnt_q   <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      valid_q <= valid_d;
    end
  end

  assign empty = cnt_q == '0;
  assign full  = cnt_q == CW'(DEPTH);
  assign head  = empty ? '0 : b;
  assign count = cnt_q;
  assign valid = valid_q;
  assign err   = err_q;

endmodule

// File: tb/tb_stack_alu.sv
// tb_stack_alu: directed plus random checks of stack_alu (W=16, DEPTH=4)
// against a queue-based reference model.
module tb_stack_alu;

  localparam int W = 16;
  localparam int D = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [W-1:0]  in = '0;
  logic [3:0]    op = '0;
  logic          apply = 1'b0;
  logic [W-1:0]  head;
  logic          empty, full, valid, err;
  logic [2:0]    count;

  int total = 0;
  int bad = 0;

  int stk[$];
  bit m_err = 0;
  bit m_valid = 0;

`ifdef STACK_ALU_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  stack_alu #(.W(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .in(in), .op(op), .apply(apply),
    .head(head), .empty(empty), .full(full), .count(count),
    .valid(valid), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int top();
    return (stk.size() == 0) ? 0 : stk[stk.size()-1];
  endfunction

  function automatic int arith(input int o, input int x, input int y);
    int r;
    case (o)
      1:  r = x + y;
      2:  r = x - y;
      12: r = y + 1;
      13: r = y - 1;
      default: r = 0;
    endcase
    if (SAT) begin
      if (r > 65535) r = 65535;
      if (r < 0) r = 0;
    end
    return r & 16'hFFFF;
  endfunction

  function automatic void model(input int o, input int v);
    int x, y, n;
    bit ok;
    n = stk.size();
    ok = 0;
    case (o)
      0: ok = 1;
      1, 2, 3, 4, 5: if (n >= 2) begin
        y = stk.pop_back();
        x = stk.pop_back();
        case (o)
          3: stk.push_back(x & y);
          4: stk.push_back(x | y);
          5: stk.push_back(x ^ y);
          default: stk.push_back(arith(o, x, y));
        endcase
        ok = 1;
      end
      6, 12, 13: if (n >= 1) begin
        y = stk.pop_back();
        stk.push_back(o == 6 ? (~y & 16'hFFFF) : arith(o, 0, y));
        ok = 1;
      end
      7: if (n < D) begin stk.push_back(v); ok = 1; end
      8: if (n >= 1) begin void'(stk.pop_back()); ok = 1; end
      9: if (n >= 1 && n < D) begin stk.push_back(top()); ok = 1; end
      10: if (n >= 2) begin
        y = stk.pop_back();
        x = stk.pop_back();
        stk.push_back(y);
        stk.push_back(x);
        ok = 1;
      end
      11: begin stk.delete(); m_err = 0; ok = 1; end
      default: ok = 0;
    endcase
    if (!ok) m_err = 1;
    m_valid = ok;
  endfunction

  task automatic check_all(input string t);
    chk({t, ".head"}, head, top());
    chk({t, ".count"}, count, stk.size());
    chk({t, ".empty"}, empty, stk.size() == 0);
    chk({t, ".full"}, full, stk.size() == D);
    chk({t, ".valid"}, valid, m_valid);
    chk({t, ".err"}, err, m_err);
  endtask

  task automatic do_op(input int o, input int v, input string t);
    @(negedge clk);
    op = 4'(o);
    in = 16'(v);
    apply = 1'b1;
    @(posedge clk);
    #1;
    model(o, v);
    check_all(t);
  endtask

  task automatic idle(input string t);
    @(negedge clk);
    apply = 1'b0;
    op = 4'($urandom);
    in = 16'($urandom);
    @(posedge clk);
    #1;
    m_valid = 0;
    check_all(t);
  endtask

  initial begin
    #2;
    check_all("reset");
    @(negedge clk);
    rst = 1'b1;

    do_op(7, 150, "push150");
    do_op(7, 0, "push0");

    do_op(11, 0, "clr_a");
    do_op(7, 7, "push7");
    do_op(7, 5, "push5");
    do_op(2, 0, "sub");
    chk("sub_lit", head, 2);
    do_op(1, 0, "add_under");
    chk("add_under_err", err, 1);

    do_op(11, 0, "clr_b");
    for (int i = 1; i <= 5; i++) do_op(7, i, "fill");
    chk("over_head", head, 4);
    do_op(11, 0, "clr_c");
    chk("clr_empty", empty, 1);

    do_op(7, 16'hFFFF, "pushffff");
    do_op(7, 1, "push1");
    do_op(1, 0, "add_ovf");
    chk("add_ovf_lit", head, SAT ? 16'hFFFF : 16'h0000);
    do_op(11, 0, "clr_d");
    do_op(7, 0, "push0b");
    do_op(13, 0, "dec_unf");
    chk("dec_unf_lit", head, SAT ? 16'h0000 : 16'hFFFF);

    do_op(11, 0, "clr_e");
    do_op(7, 3, "push3");
    do_op(7, 9, "push9");
    do_op(10, 0, "swap");
    do_op(9, 0, "dup");
    do_op(8, 0, "pop");
    do_op(6, 0, "not");
    chk("not_lit", head, 16'hFFFC);
    do_op(14, 0, "rsvd14");
    do_op(15, 0, "rsvd15");
    idle("idle");

    do_op(11, 0, "clr_f");
    do_op(7, 10, "push10");
    do_op(7, 20, "push20");
    @(negedge clk);
    apply = 1'b0;
    rst = 1'b0;
    #1;
    stk.delete();
    m_err = 0;
    m_valid = 0;
    check_all("async_rst");
    #2;
    rst = 1'b1;
    do_op(7, 1, "post_rst");

    for (int i = 0; i < 400; i++) begin
      int o;
      o = $urandom_range(0, 15);
      if ($urandom_range(0, 3) == 0) o = 7;
      if ($urandom_range(0, 29) == 0) o = 11;
      if ($urandom_range(0, 9) == 0) idle("rnd_idle");
      else do_op(o, $urandom_range(0, 65535), "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
